alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single 16-bit ALU between two requesters, for example the execute stage and the branch/address unit. A round-robin arbiter grants one request at a time and drives the ALU operands and function select from registers. It captures result/carry/zero and returns them on one response channel, tagged with the requester id, under valid/ready backpressure. Sits between the requesters and the ALU instance.

Parameters:
DATA_W, 16, operand/result width; must match the ALU (16).
OP_W, 2, function select width (00 add, 01 nand, 10 sub, 11 nop).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_a  input  DATA_W  requester 0 operand a (rs)
req0_b  input  DATA_W  requester 0 operand b (rt)
req0_op  input  OP_W  requester 0 function select
req0_ready  output  1  requester 0 request accepted this cycle
req1_valid, req1_a, req1_b, req1_op, req1_ready  same as requester 0, for requester 1
rsp_valid  output  1  response available
rsp_id  output  1  requester the response belongs to
rsp_result  output  DATA_W  captured ALU result
rsp_carry  output  1  captured ALU carry
rsp_zero  output  1  captured ALU zero
rsp_ready  input  1  consumer accepts response
alu_a  output  DATA_W  to ALU a
alu_b  output  DATA_W  to ALU b
alu_control  output  OP_W  to ALU function select
alu_result  input  DATA_W  from ALU result
alu_carry  input  1  from ALU carry
alu_zero  input  1  from ALU zero

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: alu_a=0, alu_b=0, alu_control=2'b11, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0. last_grant=1, so requester 0 wins the first tie.
- req0_ready and req1_ready are combinational. At most one is high, and only in IDLE.
- IDLE:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant: readyN=1; register a/b/op into alu_a/alu_b/alu_control; register grant id; go to EXEC.
  - With no valid request, stay in IDLE; alu_control holds 2'b11 and operands keep their last values.
- EXEC (one cycle):
  - ALU settles from the registered inputs.
  - At the clock edge, capture alu_result/carry/zero into the rsp_* registers; rsp_id = grant id; rsp_valid goes to 1; go to RESP.
  - alu_control returns to 2'b11 on entry to RESP.
- RESP:
  - rsp_valid=1 and all rsp_* fields stay stable until rsp_ready=1.
  - On handshake: rsp_valid goes to 0, last_grant = rsp_id, go to IDLE.
  - No new grant is made in RESP, even if requests are pending.
- Latency: request accepted at cycle T; rsp_valid is high from T+2. Minimum issue interval is 3 cycles per operation.
- Requester obligation: a/b/op are held stable while valid is high and ready is low. The arbiter samples them only in the ready cycle.
- Dropping valid before ready is legal; the request is simply not granted.
- Op 2'b11 (nop) goes through the full sequence and returns result 0 and zero 1.
- ALU flags are passed through unmodified. The arbiter applies no carry/zero interpretation of its own.
- Reset asserted in any state: all outputs go to reset values immediately (asynchronous). Any in-flight operation is discarded and no response is produced. After release, arbitration restarts with requester 0 priority.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...

Decomposition:
- Shared package/header alu_defs:
  - function-select constants ALU_ADD=2'b00, ALU_NAND=2'b01, ALU_SUB=2'b10, ALU_NOP=2'b11;
  - FSM state encodings S_IDLE, S_EXEC, S_RESP;
  - DATA_W default.
- One natural sub-module, rr_arb2: a combinational 2-way round-robin picker. Inputs are the two valids and last_grant; outputs are the grant one-hot and the grant id. The FSM and registers stay in alu_share_arbiter.

Test Plan:
1. req0 add a=0x7FFF b=0x0001, rsp_ready=1 -> req0_ready high at cycle 0; rsp_valid at cycle 2 with result 0x8000, carry 0, zero 0, id 0.
2. req1 add a=0xFFFF b=0x0001 -> result 0x0000, carry 1, zero 1, id 1.
3. First cycle after reset, both valid: req0 nand 0xFFFF,0xFFFF and req1 sub 0x0005,0x0003 -> req0 served first (0x0000, carry 0, zero 1); then req1 (0x0002, carry 0, zero 0, id 1).
4. Both valid continuously for 4 operations -> grant/rsp_id sequence 0,1,0,1; req0_ready and req1_ready never high together.
5. rsp_ready held low 4 cycles in RESP with req1 valid -> rsp_valid and all fields stable; req1_ready stays 0; grant occurs only after the handshake.
6. rst pulsed during EXEC of a req1 op -> outputs return to reset values in the same cycle with no response; after release, simultaneous requests grant req0 first.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter:
// ALU function selects, FSM state encoding and default datapath width.
package alu_share_arbiter_pkg;

  localparam int ALU_DATA_W = 16;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_NOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie, the requester that
// did not win last time is chosen.
module alu_share_arbiter_rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_oh_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_oh_o[0] = valid0_i & (~valid1_i | last_grant_i);
    gnt_oh_o[1] = valid1_i & (~valid0_i | ~last_grant_i);
    gnt_id_o    = gnt_oh_o[1];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: grant in IDLE, let the ALU settle
// in EXEC, then hold the tagged result in RESP until the consumer takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;

  logic              idle;
  logic [1:0]        gnt_oh;
  logic              gnt_id;

  assign idle = (state_q == S_IDLE);

  // Valids are gated by IDLE so no ready can appear in EXEC or RESP.
  alu_share_arbiter_rr_arb2 u_arb (
    .valid0_i     (req0_valid & idle),
    .valid1_i     (req1_valid & idle),
    .last_grant_i (last_grant_q),
    .gnt_oh_o     (gnt_oh),
    .gnt_id_o     (gnt_id)
  );

  assign req0_ready  = gnt_oh[0];
  assign req1_ready  = gnt_oh[1];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_zero    = rsp_zero_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctl_d    = alu_ctl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt_oh) begin
          alu_a_d    = gnt_id ? req1_a  : req0_a;
          alu_b_d    = gnt_id ? req1_b  : req0_b;
          alu_ctl_d  = gnt_id ? req1_op : req0_op;
          grant_id_d = gnt_id;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        rsp_zero_d   = alu_zero;
        rsp_id_d     = grant_id_q;
        rsp_valid_d  = 1'b1;
        alu_ctl_d    = OP_W'(ALU_NOP);
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = rsp_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= OP_W'(ALU_NOP);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 16-bit ALU attached.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_op = 2'b11, req1_op = 2'b11;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_carry, rsp_zero;
  logic [15:0] rsp_result;
  logic        rsp_ready = 1'b1;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_control;
  logic        alu_carry, alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(16), .OP_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ready(rsp_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  // Stand-in ALU; carry on subtract is the borrow out.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_control)
      ALU_ADD:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_NAND: alu_result = ~(alu_a & alu_b);
      ALU_SUB:  {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_control} !== {16'h0, 16'h0, 2'b11}) begin
      errors++; $display("FAIL reset_alu: got a=%h b=%h ctl=%b want 0000 0000 11", alu_a, alu_b, alu_control);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, req0_ready, req1_ready} !== 22'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%b r=%h c=%b z=%b rdy=%b%b want all 0",
                         rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, req0_ready, req1_ready);
    end
  endtask

  task automatic test_req0_add();
    step();
    req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL t1_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, alu_a, alu_b, alu_control} !== {1'b0, 16'h7FFF, 16'h0001, 2'b00}) begin
      errors++; $display("FAIL t1_exec: got v=%b a=%h b=%h ctl=%b want 0 7fff 0001 00", rsp_valid, alu_a, alu_b, alu_control);
    end
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, alu_control} !== {1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 2'b11}) begin
      errors++; $display("FAIL t1_rsp: got v=%b id=%b r=%h c=%b z=%b ctl=%b want 1 0 8000 0 0 11",
                         rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, alu_control);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL t1_release: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_req1_add_carry();
    bit ok;
    step();
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; req1_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL t2_ready: got %b%b want 01", req0_ready, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_id, rsp_result, rsp_carry, rsp_zero} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
      errors++; $display("FAIL t2_rsp: got ok=%b id=%b r=%h c=%b z=%b want 1 1 0000 1 1", ok, rsp_id, rsp_result, rsp_carry, rsp_zero);
    end
    step();
  endtask

  task automatic test_nop();
    bit ok;
    step();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h5678; req0_op = ALU_NOP;
    step();
    req0_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_id, rsp_result, rsp_carry, rsp_zero} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL nop_rsp: got ok=%b id=%b r=%h c=%b z=%b want 1 0 0000 0 1", ok, rsp_id, rsp_result, rsp_carry, rsp_zero);
    end
    step();
  endtask

  task automatic test_tie_after_reset();
    bit ok;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF; req0_op = ALU_NAND;
    req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0003; req1_op = ALU_SUB;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL t3_tie: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_id, rsp_result, rsp_carry, rsp_zero, req1_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL t3_first: got ok=%b id=%b r=%h c=%b z=%b rdy1=%b want 1 0 0000 0 1 0",
                         ok, rsp_id, rsp_result, rsp_carry, rsp_zero, req1_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL t3_req1_grant: got %b want 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_id, rsp_result, rsp_carry, rsp_zero} !== {1'b1, 16'h0002, 1'b0, 1'b0}) begin
      errors++; $display("FAIL t3_second: got ok=%b id=%b r=%h c=%b z=%b want 1 1 0002 0 0", ok, rsp_id, rsp_result, rsp_carry, rsp_zero);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic        exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_res [4] = '{16'h0003, 16'h0006, 16'h0003, 16'h0006};
    int n = 0;
    step();
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 16'h000A; req1_b = 16'h0004; req1_op = ALU_SUB;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (req0_ready && req1_ready) begin
        errors++; $display("FAIL b2b_both_ready: cycle %0d got 11 want at most one", cyc);
      end
      if (rsp_valid) begin
        checks++;
        if ({rsp_id, rsp_result, rsp_carry, rsp_zero} !== {exp_id[n], exp_res[n], 1'b0, 1'b0}) begin
          errors++; $display("FAIL b2b_rsp%0d: got id=%b r=%h c=%b z=%b want %b %h 0 0",
                             n, rsp_id, rsp_result, rsp_carry, rsp_zero, exp_id[n], exp_res[n]);
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d responses want 4", n);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_op = ALU_ADD;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0005; req1_op = ALU_SUB;
    wait_rsp(ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!ok || {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, req1_ready} !== {1'b1, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b id=%b r=%h c=%b z=%b rdy1=%b want 1 0 2345 0 0 0",
                           k, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, req1_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++; $display("FAIL bp_no_grant_in_resp: got %b want 0", req1_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_after_hs: got v=%b rdy1=%b want 0 1", rsp_valid, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_id, rsp_result, rsp_carry, rsp_zero} !== {1'b1, 16'hFFFE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_req1_rsp: got ok=%b id=%b r=%h c=%b z=%b want 1 1 fffe 1 0", ok, rsp_id, rsp_result, rsp_carry, rsp_zero);
    end
    step();
  endtask

  task automatic test_reset_in_exec();
    bit ok;
    step();
    req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0001; req1_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL rx_grant: req1_ready got %b want 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero} !==
        {16'h0, 16'h0, 2'b11, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rx_async: got a=%h b=%h ctl=%b v=%b id=%b r=%h c=%b z=%b want 0 0 11 0 0 0 0 0",
                         alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rx_no_rsp: rsp_valid got %b want 0", rsp_valid);
    end
    step();
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_op = ALU_NAND;
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_op = ALU_ADD;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rx_prio: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || {rsp_id, rsp_result, rsp_carry, rsp_zero} !== {1'b0, 16'hFFF0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rx_rsp: got ok=%b id=%b r=%h c=%b z=%b want 1 0 fff0 0 0", ok, rsp_id, rsp_result, rsp_carry, rsp_zero);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_req0_add();
    test_req1_add_carry();
    test_nop();
    test_tie_after_reset();
    test_back_to_back();
    test_backpressure();
    test_reset_in_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
